// File: rtl/bdl_fetch_pkg.sv
// Shared definitions for the descriptor fetch engine: word offsets, control bits, FSM states.
// Latency: none (types and constants only).
// Backpressure: none.
package bdl_fetch_pkg;

  // Descriptor word offsets within a buffer descriptor
  localparam int unsigned WORD_CTRL = 1;
  localparam int unsigned WORD_ADDR = 2;

  // Control word bit positions
  localparam int unsigned BIT_V     = 15;
  localparam int unsigned BIT_C     = 14;
  localparam int unsigned HADDR_MSB = 5;

  // Value written back to word 0 to claim a descriptor
  localparam logic [15:0] FLAG_OWNED  = 16'hC000;
  // Byte distance from one list entry to the next
  localparam logic [21:0] NEXT_OFFSET = 22'd12;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CHK  = 3'd2,
    S_FLAG = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Chain target: high bits from the control word, low bits from the address word, even byte
  function automatic logic [21:0] chain_target(input logic [5:0] haddr, input logic [14:0] laddr);
    return {haddr, laddr, 1'b0};
  endfunction

endpackage

// File: rtl/bdl_fetch_dma_timeout.sv
// DMA ack watchdog: loadable down-counter flagging the last allowed cycle of a request.
// Latency: expired asserts combinationally in the TMO-th cycle after load while en is high.
// Backpressure: none; counting pauses when en is low.
module dma_timeout #(
  parameter int unsigned TMO = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TMO + 1);

  logic [CW-1:0] cnt;

  // Reload on every new request, count down one per cycle of outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(TMO);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = en && (cnt == CW'(1));

endmodule

// File: rtl/bdl_fetch.sv
// Descriptor fetch engine: reads NUM descriptor words into the BDL file, follows chains, claims entry.
// Latency: 3 cycles per DMA word with 1-cycle ack, plus CHK/DONE cycles; done pulses once per start.
// Backpressure: each DMA request is held until dma_ack/dma_nxm or TMO expiry; start ignored while busy.
module bdl_fetch
  import bdl_fetch_pkg::*;
#(
  parameter int unsigned NUM       = 4,
  parameter int unsigned MAX_CHAIN = 8,
  parameter int unsigned TMO       = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [21:0]          desc_addr,
  output logic                 dma_req,
  output logic                 dma_wr,
  output logic [21:0]          dma_addr,
  output logic [15:0]          dma_wdata,
  input  logic                 dma_ack,
  input  logic [15:0]          dma_rdata,
  input  logic                 dma_nxm,
  output logic [NUM/2-1:0]     bdl_addr,
  output logic [15:0]          bdl_data,
  output logic                 bdl_we,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic                 err_nxm,
  output logic                 err_chain,
  output logic [21:0]          next_addr
);

  localparam int unsigned KW  = NUM / 2;
  localparam int unsigned CCW = $clog2(MAX_CHAIN + 1);

  state_t          state;
  logic [21:0]     cur;
  logic [KW-1:0]   k;
  logic [CCW-1:0]  chain_cnt;
  logic            d_v;
  logic            d_c;
  logic [5:0]      d_haddr;
  logic [14:0]     d_laddr;
  logic            tmr_load;
  logic            tmr_expired;
  logic            abort;

  // A request is about to be raised whenever a DMA state has none outstanding
  assign tmr_load = ((state == S_RD) || (state == S_FLAG)) && !dma_req;
  // NXM beats a simultaneous ack; timeout only counts when no ack arrived
  assign abort    = dma_req && (dma_nxm || (tmr_expired && !dma_ack));

  dma_timeout #(.TMO(TMO)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .en      (dma_req),
    .expired (tmr_expired)
  );

  // Fetch sequencer with registered DMA, BDL and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cur       <= '0;
      k         <= '0;
      chain_cnt <= '0;
      d_v       <= 1'b0;
      d_c       <= 1'b0;
      d_haddr   <= '0;
      d_laddr   <= '0;
      dma_req   <= 1'b0;
      dma_wr    <= 1'b0;
      dma_addr  <= '0;
      dma_wdata <= '0;
      bdl_addr  <= '0;
      bdl_data  <= '0;
      bdl_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      err_nxm   <= 1'b0;
      err_chain <= 1'b0;
      next_addr <= '0;
    end else begin
      bdl_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cur       <= {desc_addr[21:1], 1'b0};
            chain_cnt <= '0;
            valid     <= 1'b0;
            err_nxm   <= 1'b0;
            err_chain <= 1'b0;
            busy      <= 1'b1;
            k         <= '0;
            state     <= S_RD;
          end
        end
        S_RD: begin
          if (!dma_req) begin
            dma_req  <= 1'b1;
            dma_wr   <= 1'b0;
            dma_addr <= cur + 22'({k, 1'b0});
          end else if (abort) begin
            dma_req <= 1'b0;
            err_nxm <= 1'b1;
            done    <= 1'b1;
            state   <= S_DONE;
          end else if (dma_ack) begin
            dma_req  <= 1'b0;
            bdl_we   <= 1'b1;
            bdl_addr <= k;
            bdl_data <= dma_rdata;
            if (k == KW'(WORD_CTRL)) begin
              d_v     <= dma_rdata[BIT_V];
              d_c     <= dma_rdata[BIT_C];
              d_haddr <= dma_rdata[HADDR_MSB:0];
            end
            if (k == KW'(WORD_ADDR)) begin
              d_laddr <= dma_rdata[15:1];
            end
            if (k == KW'(NUM - 1)) begin
              state <= S_CHK;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        S_CHK: begin
          if (!d_v) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (d_c) begin
            if (chain_cnt == CCW'(MAX_CHAIN)) begin
              err_chain <= 1'b1;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              cur       <= chain_target(d_haddr, d_laddr);
              chain_cnt <= chain_cnt + CCW'(1);
              k         <= '0;
              state     <= S_RD;
            end
          end else begin
            state <= S_FLAG;
          end
        end
        S_FLAG: begin
          if (!dma_req) begin
            dma_req   <= 1'b1;
            dma_wr    <= 1'b1;
            dma_addr  <= cur;
            dma_wdata <= FLAG_OWNED;
          end else if (abort) begin
            dma_req <= 1'b0;
            err_nxm <= 1'b1;
            done    <= 1'b1;
            state   <= S_DONE;
          end else if (dma_ack) begin
            dma_req   <= 1'b0;
            valid     <= 1'b1;
            next_addr <= cur + NEXT_OFFSET;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bdl_fetch.sv
// Scoreboard bench for bdl_fetch: memory responder, expected DMA/BDL queues, per-scenario tasks.
module tb_bdl_fetch;

  localparam int NUM = 4;
  localparam int MAX_CHAIN = 8;
  localparam int TMO = 255;

  logic        clk;
  logic        reset;
  logic        start;
  logic [21:0] desc_addr;
  logic        dma_req;
  logic        dma_wr;
  logic [21:0] dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_ack;
  logic [15:0] dma_rdata;
  logic        dma_nxm;
  logic [1:0]  bdl_addr;
  logic [15:0] bdl_data;
  logic        bdl_we;
  logic        busy;
  logic        done;
  logic        valid;
  logic        err_nxm;
  logic        err_chain;
  logic [21:0] next_addr;

  bdl_fetch #(.NUM(NUM), .MAX_CHAIN(MAX_CHAIN), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .desc_addr(desc_addr),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_nxm(dma_nxm),
    .bdl_addr(bdl_addr), .bdl_data(bdl_data), .bdl_we(bdl_we),
    .busy(busy), .done(done), .valid(valid), .err_nxm(err_nxm), .err_chain(err_chain),
    .next_addr(next_addr)
  );

  typedef struct packed {logic wr; logic [21:0] addr; logic [15:0] wdata;} dma_t;
  typedef struct packed {logic [1:0] a; logic [15:0] d;} bdl_t;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int last_req_len = 0;
  logic [15:0] mem [logic [21:0]];
  dma_t exp_dma[$];
  bdl_t exp_bdl[$];
  bit hang_en = 0;
  bit nxm_en = 0;
  bit nxm_with_ack = 0;
  logic [21:0] nxm_addr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_rd(input logic [21:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  // Memory slave: checks each new request against the expected cycle, answers on its 2nd cycle
  initial begin : responder
    int age;
    dma_t e;
    age = 0;
    dma_ack = 1'b0;
    dma_nxm = 1'b0;
    dma_rdata = 16'h0;
    forever begin
      @(negedge clk);
      dma_ack = 1'b0;
      dma_nxm = 1'b0;
      if (dma_req === 1'b1) begin
        age++;
        if (age == 1) begin
          checks++;
          if (exp_dma.size() == 0) begin
            errors++;
            $display("FAIL dma_cycle: got wr=%0b addr=%06h wdata=%04h, required no cycle", dma_wr, dma_addr, dma_wdata);
          end else begin
            e = exp_dma.pop_front();
            if (dma_wr !== e.wr || dma_addr !== e.addr || (e.wr && dma_wdata !== e.wdata)) begin
              errors++;
              $display("FAIL dma_cycle: got wr=%0b addr=%06h wdata=%04h, required wr=%0b addr=%06h wdata=%04h",
                       dma_wr, dma_addr, dma_wdata, e.wr, e.addr, e.wdata);
            end
          end
        end
        if (age == 2 && !hang_en) begin
          if (nxm_en && dma_addr == nxm_addr) begin
            dma_nxm = 1'b1;
            dma_ack = nxm_with_ack;
            dma_rdata = 16'hDEAD;
          end else begin
            dma_ack = 1'b1;
            if (dma_wr) mem[dma_addr] = dma_wdata;
            else dma_rdata = mem_rd(dma_addr);
          end
        end
      end else begin
        if (age != 0) last_req_len = age;
        age = 0;
      end
    end
  end

  // BDL write monitor against the expected write queue
  always @(negedge clk) begin
    bdl_t e;
    if (bdl_we === 1'b1) begin
      checks++;
      if (exp_bdl.size() == 0) begin
        errors++;
        $display("FAIL bdl_write: got addr=%0d data=%04h, required no write", bdl_addr, bdl_data);
      end else begin
        e = exp_bdl.pop_front();
        if (bdl_addr !== e.a || bdl_data !== e.d) begin
          errors++;
          $display("FAIL bdl_write: got addr=%0d data=%04h, required addr=%0d data=%04h", bdl_addr, bdl_data, e.a, e.d);
        end
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic set_desc(input logic [21:0] a, input logic [15:0] w0, w1, w2, w3);
    mem[a] = w0;
    mem[a + 22'd2] = w1;
    mem[a + 22'd4] = w2;
    mem[a + 22'd6] = w3;
  endtask

  // Push the expected reads and BDL writes of one full descriptor fetch
  task automatic expect_fetch(input logic [21:0] base);
    logic [21:0] a;
    for (int i = 0; i < NUM; i++) begin
      a = base + 22'(2 * i);
      exp_dma.push_back('{wr: 1'b0, addr: a, wdata: 16'h0});
      exp_bdl.push_back('{a: 2'(i), d: mem_rd(a)});
    end
  endtask

  task automatic expect_flag(input logic [21:0] a);
    exp_dma.push_back('{wr: 1'b1, addr: a, wdata: 16'hC000});
  endtask

  task automatic pulse_start(input logic [21:0] a);
    @(negedge clk);
    desc_addr = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done: got no done within %0d cycles, required done pulse", name, budget);
    end
  endtask

  task automatic check_status(input string name, input logic v, en, ec);
    checks++;
    if (valid !== v || err_nxm !== en || err_chain !== ec) begin
      errors++;
      $display("FAIL %s_status: got valid=%0b err_nxm=%0b err_chain=%0b, required %0b %0b %0b",
               name, valid, err_nxm, err_chain, v, en, ec);
    end
  endtask

  task automatic check_drained(input string name);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_dma.size() != 0 || exp_bdl.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drained: got dma_left=%0d bdl_left=%0d busy=%0b, required 0 0 0",
               name, exp_dma.size(), exp_bdl.size(), busy);
    end
    exp_dma.delete();
    exp_bdl.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({dma_req, dma_wr, dma_addr, dma_wdata, bdl_addr, bdl_data, bdl_we, busy, done,
         valid, err_nxm, err_chain, next_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%0b addr=%06h bdl_we=%0b busy=%0b next=%06h, required all zero",
               dma_req, dma_addr, bdl_we, busy, next_addr);
    end
  endtask

  task automatic test_basic();
    int d0;
    set_desc(22'h001000, 16'h8000, 16'h8003, 16'h4000, 16'hFF00);
    expect_fetch(22'h001000);
    expect_flag(22'h001000);
    d0 = done_cnt;
    pulse_start(22'h001000);
    wait_done("basic", 200);
    check_status("basic", 1'b1, 1'b0, 1'b0);
    checks++;
    if (next_addr !== 22'h00100C) begin
      errors++;
      $display("FAIL basic_next_addr: got %06h, required 00100c", next_addr);
    end
    check_drained("basic");
    checks++;
    if (done_cnt - d0 != 1 || mem_rd(22'h001000) !== 16'hC000) begin
      errors++;
      $display("FAIL basic_done_flag: got pulses=%0d word0=%04h, required 1 c000", done_cnt - d0, mem_rd(22'h001000));
    end
  endtask

  task automatic test_end_of_list();
    set_desc(22'h002000, 16'h1234, 16'h0000, 16'h5678, 16'h9ABC);
    expect_fetch(22'h002000);
    pulse_start(22'h002001);
    wait_done("eol", 200);
    check_status("eol", 1'b0, 1'b0, 1'b0);
    check_drained("eol");
  endtask

  task automatic test_chain();
    set_desc(22'h003000, 16'h0001, 16'hC001, 16'h2000, 16'h0003);
    set_desc(22'h012000, 16'h0002, 16'h8000, 16'h0000, 16'h0004);
    expect_fetch(22'h003000);
    expect_fetch(22'h012000);
    expect_flag(22'h012000);
    pulse_start(22'h003000);
    wait_done("chain", 300);
    check_status("chain", 1'b1, 1'b0, 1'b0);
    checks++;
    if (next_addr !== 22'h01200C || mem_rd(22'h003000) !== 16'h0001) begin
      errors++;
      $display("FAIL chain_result: got next=%06h wordA0=%04h, required 01200c 0001", next_addr, mem_rd(22'h003000));
    end
    check_drained("chain");
  endtask

  task automatic test_self_chain();
    set_desc(22'h004000, 16'h0000, 16'hC000, 16'h4000, 16'h0000);
    for (int i = 0; i <= MAX_CHAIN; i++) expect_fetch(22'h004000);
    pulse_start(22'h004000);
    wait_done("loop", 2000);
    check_status("loop", 1'b0, 1'b0, 1'b1);
    check_drained("loop");
  endtask

  task automatic test_nxm();
    set_desc(22'h005000, 16'h0005, 16'h8000, 16'h0000, 16'h0006);
    for (int i = 0; i < 3; i++) exp_dma.push_back('{wr: 1'b0, addr: 22'h005000 + 22'(2 * i), wdata: 16'h0});
    exp_bdl.push_back('{a: 2'd0, d: 16'h0005});
    exp_bdl.push_back('{a: 2'd1, d: 16'h8000});
    nxm_en = 1;
    nxm_with_ack = 1;
    nxm_addr = 22'h005004;
    pulse_start(22'h005000);
    wait_done("nxm", 200);
    nxm_en = 0;
    nxm_with_ack = 0;
    check_status("nxm", 1'b0, 1'b1, 1'b0);
    check_drained("nxm");
  endtask

  task automatic test_timeout();
    exp_dma.push_back('{wr: 1'b0, addr: 22'h006000, wdata: 16'h0});
    hang_en = 1;
    pulse_start(22'h006000);
    wait_done("tmo", 1000);
    hang_en = 0;
    check_status("tmo", 1'b0, 1'b1, 1'b0);
    check_drained("tmo");
    checks++;
    if (last_req_len != TMO) begin
      errors++;
      $display("FAIL tmo_req_len: got %0d cycles, required %0d", last_req_len, TMO);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    set_desc(22'h007000, 16'h0007, 16'h8000, 16'h0000, 16'h0008);
    exp_dma.push_back('{wr: 1'b0, addr: 22'h007000, wdata: 16'h0});
    pulse_start(22'h007000);
    for (int i = 0; i < 20; i++) begin
      if (dma_req === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (!seen || dma_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got req_seen=%0b dma_req=%0b busy=%0b, required 1 0 0", seen, dma_req, busy);
    end
    check_drained("reset_mid");
  endtask

  task automatic test_back_to_back();
    set_desc(22'h008000, 16'h0009, 16'h8000, 16'h0000, 16'h000A);
    set_desc(22'h009000, 16'h000B, 16'h8000, 16'h0000, 16'h000C);
    expect_fetch(22'h008000);
    expect_flag(22'h008000);
    pulse_start(22'h008000);
    repeat (4) @(negedge clk);
    desc_addr = 22'h009000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 200);
    desc_addr = 22'h009000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (next_addr !== 22'h00800C || mem_rd(22'h009000) !== 16'h000B) begin
      errors++;
      $display("FAIL busy_start: got next=%06h word9000=%04h, required 00800c 000b", next_addr, mem_rd(22'h009000));
    end
    check_drained("busy_start");
  endtask

  task automatic test_wrap();
    set_desc(22'h3FFFFA, 16'h1111, 16'h8000, 16'h0000, 16'h2222);
    expect_fetch(22'h3FFFFA);
    expect_flag(22'h3FFFFA);
    pulse_start(22'h3FFFFA);
    wait_done("wrap", 200);
    check_status("wrap", 1'b1, 1'b0, 1'b0);
    checks++;
    if (next_addr !== 22'h000006 || mem_rd(22'h000000) !== 16'h2222) begin
      errors++;
      $display("FAIL wrap_addr: got next=%06h word0=%04h, required 000006 2222", next_addr, mem_rd(22'h000000));
    end
    check_drained("wrap");
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset = 1'b1;
    start = 1'b0;
    desc_addr = '0;
    test_reset();
    test_basic();
    test_end_of_list();
    test_chain();
    test_self_chain();
    test_nxm();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
